// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow straight from IDLE.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      op_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            special_reg;
  logic [XLEN-1:0] spec_res_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_out_reg;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] spec_val;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            take;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fix_val;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & operand_a[XLEN-1];
  assign b_neg     = is_signed & operand_b[XLEN-1];
  assign mag_a     = a_neg ? ('0 - operand_a) : operand_a;
  assign mag_b     = b_neg ? ('0 - operand_b) : operand_b;
  assign div_zero  = (operand_b == '0);
  assign overflow  = is_signed & (operand_a == MIN_NEG) & (&operand_b);
  // Special results are fixed at issue time so they never depend on the iteration.
  assign spec_val  = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_NEG);

  // A negative trial difference shows up in the extra top bit.
  assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvs_reg};
  assign take      = ~diff[XLEN];

  assign q_fix   = neg_q_reg ? ('0 - quo_reg) : quo_reg;
  assign r_fix   = neg_r_reg ? ('0 - rem_reg) : rem_reg;
  assign fix_val = special_reg ? spec_res_reg : (op_reg[1] ? r_fix : q_fix);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      rd_reg       <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dvs_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      special_reg  <= 1'b0;
      spec_res_reg <= '0;
      result_reg   <= '0;
      rd_out_reg   <= '0;
    end else if (kill) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg       <= op;
            rd_reg       <= rd_in;
            quo_reg      <= mag_a;
            dvs_reg      <= mag_b;
            rem_reg      <= '0;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            special_reg  <= div_zero | overflow;
            spec_res_reg <= spec_val;
            cnt_reg      <= '0;
`ifdef DIV_FAST_SPECIAL_EN
            if (div_zero | overflow) begin
              result_reg <= spec_val;
              rd_out_reg <= rd_in;
              state_reg  <= DONE;
            end else begin
              state_reg  <= CALC;
            end
`else
            state_reg    <= CALC;
`endif
          end
        end
        CALC: begin
          quo_reg <= {quo_reg[XLEN-2:0], take};
          rem_reg <= take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
          if (cnt_reg == CW'(XLEN-1)) begin
            cnt_reg   <= '0;
            state_reg <= FIX;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          result_reg <= fix_val;
          rd_out_reg <= rd_reg;
          state_reg  <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against an arithmetic reference model, with pinned literal cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int NORM_LAT = 34;

  int n_checks = 0;
  int n_fail   = 0;

  bit          exp_valid = 1'b0;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  int          exp_lat;
  int          lat_cnt;
  int          busy_cnt;
  int          last_lat;
  int          last_busy;
  logic [31:0] hold_res = '0;
  logic [4:0]  hold_rd  = '0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .arst(arst), .start(start), .kill(kill), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: plain integer division with the RISC-V special-case rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'(sa / sb);
      2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return 32'h0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Per-cycle checker: outputs are compared every cycle against the expected transaction state.
  always @(negedge clk) begin
    if (!arst) begin
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_rd_out", {27'b0, rd_out}, 32'h0);
    end else begin
      if (exp_valid) lat_cnt++;
      chk("busy", {31'b0, busy}, {31'b0, exp_valid});
      if (!exp_valid) chk("spurious_done", {31'b0, done}, 32'h0);
      if (done && exp_valid) begin
        chk("result", result, exp_res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, exp_rd});
        chk("latency", lat_cnt, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat - 1);
        $display("op done: result=%h rd=%0d latency=%0d", result, rd_out, lat_cnt);
        hold_res  = exp_res;
        hold_rd   = exp_rd;
        last_lat  = lat_cnt;
        last_busy = busy_cnt;
        exp_valid = 1'b0;
      end else begin
        if (exp_valid && busy) busy_cnt++;
        chk("hold_result", result, hold_res);
        chk("hold_rd_out", {27'b0, rd_out}, {27'b0, hold_rd});
      end
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op = o; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_res   = model(o, a, b);
    exp_rd    = rd;
    exp_lat   = is_special(o, a, b) ? SPEC_LAT : NORM_LAT;
    lat_cnt   = 0;
    busy_cnt  = 0;
    exp_valid = 1'b1;
  endtask

  // Waits for the pending op; with noise, start and operands toggle while busy and must be ignored.
  task automatic wait_done(input bit noise);
    int guard = 0;
    while (exp_valid && guard < 100) begin
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op        = 2'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      rd_in     = 5'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (exp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done expected done within 100 cycles");
      exp_valid = 1'b0;
    end
  endtask

  task automatic run_lit(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lit_lat);
    start_op(o, a, b, rd);
    wait_done(1'b0);
    chk("lit_result", result, lit);
    chk("lit_model", model(o, a, b), lit);
    chk("lit_latency", last_lat, lit_lat);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    arst = 1'b0; start = 1'b0; kill = 1'b0; op = '0;
    operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    @(posedge clk); #1;

    run_lit(2'b00, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    chk("lit_rd_out", {27'b0, rd_out}, 32'd5);
    chk("lit_busy_cycles", last_busy, 33);
    run_lit(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 34);
    run_lit(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'h0000_0001, 34);
    run_lit(2'b01, 32'h1234_5678, 32'd0, 5'd3, 32'hFFFF_FFFF, SPEC_LAT);
    run_lit(2'b10, 32'h1234_5678, 32'd0, 5'd4, 32'h1234_5678, SPEC_LAT);
    run_lit(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, SPEC_LAT);
    run_lit(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h0, SPEC_LAT);

    // Kill in CALC cycle 10 with a concurrent start: must drop to IDLE, no done.
    start_op(2'b01, 32'd1000, 32'd3, 5'd9);
    repeat (9) begin start = 1'b1; @(posedge clk); #1; end
    kill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0; exp_valid = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk); #1;

    // Kill beats start in IDLE.
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("kill_over_start", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;

    // Asynchronous reset at CALC cycle 20.
    start_op(2'b00, 32'd12345, 32'd17, 5'd11);
    repeat (19) @(posedge clk); #1;
    #2 arst = 1'b0;
    exp_valid = 1'b0; hold_res = '0; hold_rd = '0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_result", result, 32'h0);
    chk("async_rst_rd_out", {27'b0, rd_out}, 32'h0);
    @(posedge clk); #1;
    arst = 1'b1;
    run_lit(2'b01, 32'd9, 32'd3, 5'd12, 32'd3, 34);

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 9))
        0:       begin a = $urandom; b = 32'h0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      start_op(o, a, b, 5'($urandom));
      wait_done(1'b1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input arst, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have input start, 1 bit, requesting a new divide; it is sampled only in IDLE.
REQ-005 The block SHALL have input kill, 1 bit, which aborts any operation in flight.
REQ-006 The block SHALL have input op, 2 bits, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The block SHALL have inputs operand_a and operand_b, XLEN bits each, the dividend and divisor taken from the register-file read ports.
REQ-008 The block SHALL have input rd_in, 5 bits, the destination register tag.
REQ-009 The block SHALL have output busy, 1 bit, high in any state other than IDLE.
REQ-010 The block SHALL have output done, 1 bit, a one-cycle pulse marking result valid, for use as the register-file write enable.
REQ-011 The block SHALL have output result, XLEN bits, the quotient or remainder, for use as the register-file write data.
REQ-012 The block SHALL have output rd_out, 5 bits, the write address captured at start.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1 and kill=0, the block SHALL latch op, rd_in, the operand magnitudes and the sign flags, clear the remainder, and go to CALC.
REQ-015 In CALC, the block SHALL do one restoring shift-subtract step per cycle for exactly XLEN cycles, counted by a counter that wraps to 0, and then go to FIX.
REQ-016 In FIX, the block SHALL apply the sign correction (quotient negated if the operand signs differ, remainder takes the dividend's sign; signed ops only), select quotient or remainder, and go to DONE.
REQ-017 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 Latency SHALL be XLEN+2 cycles from the edge sampling start to the cycle where done=1.
REQ-019 result and rd_out SHALL hold their values after done until the next DONE state.
REQ-020 Divide by zero SHALL give all ones for DIV and DIVU, and operand_a for REM and REMU.
REQ-021 Signed overflow (DIV of the most-negative value by -1) SHALL give the most-negative value for DIV and 0 for REM.
REQ-022 The block SHALL ignore start when not in IDLE, so that no second operation is queued.
REQ-023 When kill=1, the block SHALL enter IDLE on the next edge from any state, with no done pulse; kill SHALL win over a simultaneous start.
REQ-024 start=1 in the DONE cycle SHALL be ignored; start is accepted again from the following IDLE cycle.

Reset
REQ-025 While arst=0, the block SHALL force state IDLE and set busy=0, done=0, result=0, rd_out=0, the counter to 0 and all internal registers to 0, asynchronously.
REQ-026 A reset asserted mid-operation SHALL discard that operation with no done pulse.
REQ-027 After arst is released, the first start SHALL be accepted at the first rising edge.

Configuration
REQ-028 The macro DIV_FAST_SPECIAL_EN SHALL select the handling of special cases.
REQ-029 With DIV_FAST_SPECIAL_EN defined, divide by zero and signed overflow SHALL go from IDLE directly to DONE, with done asserted 1 cycle after the start edge.
REQ-030 Without DIV_FAST_SPECIAL_EN, special cases SHALL pass through CALC and FIX with latency XLEN+2 and produce identical result values.

Verification
REQ-031 The bench SHALL check: DIV 100 by 7 with rd_in=5 -> result=14, rd_out=5, done exactly 34 cycles after the start edge, busy high for 33 cycles.
REQ-032 The bench SHALL check: REM -7 (0xFFFFFFF9) by 2 -> result=0xFFFFFFFF; REMU with the same operands -> result=0x00000001.
REQ-033 The bench SHALL check: DIVU 0x12345678 by 0 -> result=0xFFFFFFFF; REM 0x12345678 by 0 -> result=0x12345678; latency 1 cycle with DIV_FAST_SPECIAL_EN and 34 without.
REQ-034 The bench SHALL check: DIV 0x80000000 by 0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0.
REQ-035 The bench SHALL check: kill at CALC cycle 10 -> busy=0 on the next cycle, no done pulse; a start issued during CALC is ignored.
REQ-036 The bench SHALL check: arst pulsed low at CALC cycle 20 -> all outputs 0 immediately; a fresh DIVU 9 by 3 -> result=3.
